// File: rtl/screen_sequencer.sv
// Game-flow controller: MENU -> COUNTDOWN -> GAME -> END -> MENU, with winner
// latching, timed END screen and a one-cycle reset pulse for the race datapath.
module screen_sequencer #(
  parameter int COUNTDOWN_CLK_COUNT = 1,
  parameter int COUNTDOWN_STEPS     = 3,
  parameter int END_TIMER_CLK_COUNT = 1,
  parameter int PLAYERS             = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic [PLAYERS-1:0] player_finish,
  output logic [1:0]         current_screen,
  output logic [1:0]         countdown_value,
  output logic               game_enable,
  output logic [1:0]         winner,
  output logic               winner_valid,
  output logic               trigger_reset_all
);

  localparam logic [1:0] S_MENU      = 2'b00;
  localparam logic [1:0] S_COUNTDOWN = 2'b11;
  localparam logic [1:0] S_GAME      = 2'b01;
  localparam logic [1:0] S_END       = 2'b10;

  localparam int CD_W  = (COUNTDOWN_CLK_COUNT > 1) ? $clog2(COUNTDOWN_CLK_COUNT) : 1;
  localparam int END_W = (END_TIMER_CLK_COUNT > 1) ? $clog2(END_TIMER_CLK_COUNT) : 1;

  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COUNTDOWN_CLK_COUNT - 1);
  localparam logic [END_W-1:0] END_LAST = END_W'(END_TIMER_CLK_COUNT - 1);
  localparam logic [1:0]       CD_START = 2'(COUNTDOWN_STEPS);

  logic [1:0]       screen_q, screen_d;
  logic [1:0]       countdown_q, countdown_d;
  logic [CD_W-1:0]  cd_cnt_q, cd_cnt_d;
  logic [END_W-1:0] end_cnt_q, end_cnt_d;
  logic [1:0]       winner_q, winner_d;
  logic             winner_valid_q, winner_valid_d;
  logic             trig_q, trig_d;
  logic             start_q, start_d;
  logic             start_rise;
  logic [1:0]       first_idx;

  assign start_rise = start_btn & ~start_q;

  // Scanning from the top down lets the lowest set index win on ties.
  always_comb begin
    first_idx = '0;
    for (int i = PLAYERS - 1; i >= 0; i--) begin
      if (player_finish[i]) first_idx = 2'(i);
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q value so no path through the case leaves one unassigned (no latches).
    screen_d       = screen_q;
    countdown_d    = countdown_q;
    cd_cnt_d       = cd_cnt_q;
    end_cnt_d      = end_cnt_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    trig_d         = 1'b0;
    start_d        = start_btn;

    case (screen_q)
      S_MENU: begin
        if (start_rise) begin
          screen_d    = S_COUNTDOWN;
          countdown_d = CD_START;
          cd_cnt_d    = '0;
        end
      end
      S_COUNTDOWN: begin
        if (cd_cnt_q == CD_LAST) begin
          cd_cnt_d = '0;
          if (countdown_q == 2'd1) begin
            screen_d    = S_GAME;
            countdown_d = 2'd0;
          end else begin
            countdown_d = countdown_q - 2'd1;
          end
        end else begin
          cd_cnt_d = cd_cnt_q + CD_W'(1);
        end
      end
      S_GAME: begin
        if (|player_finish) begin
          screen_d       = S_END;
          winner_d       = first_idx;
          winner_valid_d = 1'b1;
          end_cnt_d      = '0;
        end
      end
      S_END: begin
        // Early exit on start_rise shares the normal timeout path, so the pulse fires once.
        if ((end_cnt_q == END_LAST) || start_rise) begin
          screen_d       = S_MENU;
          trig_d         = 1'b1;
          winner_valid_d = 1'b0;
        end else begin
          end_cnt_d = end_cnt_q + END_W'(1);
        end
      end
      default: screen_d = S_MENU;
    endcase
  end

  // start_q resets to 1 so a button held through reset release is not seen as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      screen_q       <= S_MENU;
      countdown_q    <= 2'd0;
      cd_cnt_q       <= '0;
      end_cnt_q      <= '0;
      winner_q       <= 2'd0;
      winner_valid_q <= 1'b0;
      trig_q         <= 1'b0;
      start_q        <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      screen_q       <= screen_d;
      countdown_q    <= countdown_d;
      cd_cnt_q       <= cd_cnt_d;
      end_cnt_q      <= end_cnt_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      trig_q         <= trig_d;
      start_q        <= start_d;
    end
  end

  assign current_screen    = screen_q;
  assign countdown_value   = countdown_q;
  assign game_enable       = (screen_q == S_GAME);
  assign winner            = winner_q;
  assign winner_valid      = winner_valid_q;
  assign trigger_reset_all = trig_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed self-checking bench for screen_sequencer with
// COUNTDOWN_CLK_COUNT=4, COUNTDOWN_STEPS=3, END_TIMER_CLK_COUNT=5, PLAYERS=4.
module tb_screen_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [3:0] player_finish;
  logic [1:0] current_screen;
  logic [1:0] countdown_value;
  logic       game_enable;
  logic [1:0] winner;
  logic       winner_valid;
  logic       trigger_reset_all;

  int checks   = 0;
  int failures = 0;

  screen_sequencer #(
    .COUNTDOWN_CLK_COUNT(4),
    .COUNTDOWN_STEPS    (3),
    .END_TIMER_CLK_COUNT(5),
    .PLAYERS            (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_btn        (start_btn),
    .player_finish    (player_finish),
    .current_screen   (current_screen),
    .countdown_value  (countdown_value),
    .game_enable      (game_enable),
    .winner           (winner),
    .winner_valid     (winner_valid),
    .trigger_reset_all(trigger_reset_all)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".screen"}, 8'(current_screen), 8'h0);
    check({tag, ".cd"},     8'(countdown_value), 8'h0);
    check({tag, ".ge"},     8'(game_enable), 8'h0);
    check({tag, ".trig"},   8'(trigger_reset_all), 8'h0);
  endtask

  initial begin
    reset         = 1'b1;
    start_btn     = 1'b1;
    player_finish = 4'b0000;
    step();
    step();
    check_idle("rst");
    check("rst.winner", 8'(winner), 8'h0);
    check("rst.valid",  8'(winner_valid), 8'h0);

    // 1: button held through reset release never starts a race
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("held.%0d", k), 8'(current_screen), 8'h0);
    end
    start_btn = 1'b0;
    step();
    check("held.low", 8'(current_screen), 8'h0);
    start_btn = 1'b1;
    step();
    check("start.screen", 8'(current_screen), 8'h3);
    start_btn = 1'b0;

    // 2: countdown shows 3,2,1 for four cycles each
    for (int k = 0; k < 12; k++) begin
      check($sformatf("cd.screen.%0d", k), 8'(current_screen), 8'h3);
      check($sformatf("cd.value.%0d", k),  8'(countdown_value), 8'(3 - k / 4));
      check($sformatf("cd.ge.%0d", k),     8'(game_enable), 8'h0);
      step();
    end
    check("game.screen", 8'(current_screen), 8'h1);
    check("game.ge",     8'(game_enable), 8'h1);
    check("game.cd",     8'(countdown_value), 8'h0);

    // 6 (part): start rises in GAME are ignored
    start_btn = 1'b1;
    step();
    check("game.start1", 8'(current_screen), 8'h1);
    start_btn = 1'b0;
    step();
    check("game.start0", 8'(current_screen), 8'h1);

    // 3: simultaneous finish resolves to lowest index, END lasts five cycles
    player_finish = 4'b0110;
    step();
    player_finish = 4'b0000;
    check("end.screen", 8'(current_screen), 8'h2);
    check("end.winner", 8'(winner), 8'h1);
    check("end.valid",  8'(winner_valid), 8'h1);
    check("end.ge",     8'(game_enable), 8'h0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("end.hold.%0d", k), 8'(current_screen), 8'h2);
      check($sformatf("end.trig.%0d", k), 8'(trigger_reset_all), 8'h0);
      step();
    end
    check("ret.screen", 8'(current_screen), 8'h0);
    check("ret.trig",   8'(trigger_reset_all), 8'h1);
    check("ret.valid",  8'(winner_valid), 8'h0);
    check("ret.winner", 8'(winner), 8'h1);
    step();
    check("ret.trig2",  8'(trigger_reset_all), 8'h0);
    check("ret.screen2", 8'(current_screen), 8'h0);

    // 4: early exit from END on start rise in its second cycle
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("e4.cd", 8'(current_screen), 8'h3);
    for (int k = 0; k < 12; k++) step();
    check("e4.game", 8'(current_screen), 8'h1);
    player_finish = 4'b0001;
    step();
    player_finish = 4'b0000;
    check("e4.end1",   8'(current_screen), 8'h2);
    check("e4.winner", 8'(winner), 8'h0);
    step();
    check("e4.end2", 8'(current_screen), 8'h2);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    check("e4.menu",  8'(current_screen), 8'h0);
    check("e4.trig",  8'(trigger_reset_all), 8'h1);
    check("e4.valid", 8'(winner_valid), 8'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("e4.notrig.%0d", k), 8'(trigger_reset_all), 8'h0);
      check($sformatf("e4.stay.%0d", k),   8'(current_screen), 8'h0);
    end

    // 5: asynchronous reset mid-COUNTDOWN
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("r5.pre.screen", 8'(current_screen), 8'h3);
    check("r5.pre.cd",     8'(countdown_value), 8'h2);
    #2;
    reset = 1'b1;
    #1;
    check_idle("r5.async");
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("r5.trig.%0d", k), 8'(trigger_reset_all), 8'h0);
    end
    reset = 1'b0;
    step();
    check_idle("r5.rel");

    // 6: player_finish held in MENU and COUNTDOWN is ignored
    player_finish = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("p6.menu.%0d", k), 8'(current_screen), 8'h0);
    end
    check("p6.menu.valid", 8'(winner_valid), 8'h0);
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("p6.cd.%0d", k), 8'(current_screen), 8'h3);
      step();
    end
    check("p6.game",    8'(current_screen), 8'h1);
    check("p6.game.ge", 8'(game_enable), 8'h1);
    step();
    check("p6.end",    8'(current_screen), 8'h2);
    check("p6.winner", 8'(winner), 8'h3);
    check("p6.valid",  8'(winner_valid), 8'h1);
    player_finish = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
- Top-level game-flow controller. Sequences the screens MENU -> COUNTDOWN -> GAME -> END -> MENU and drives `current_screen` to the screen renderers and the end-game timer logic.
- Latches the winning player and times the END screen.
- Issues the one-cycle `trigger_reset_all` pulse that re-initialises the race datapath.

Parameters:
- COUNTDOWN_CLK_COUNT, 1: clocks per countdown step (>=1).
- COUNTDOWN_STEPS, 3: number of countdown steps shown before the race (1..3).
- END_TIMER_CLK_COUNT, 1: clocks spent on the END screen before the automatic return to MENU (>=1).
- PLAYERS, 4: number of players (1..4).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_btn  in  1  start button level, already synchronised; only rising edges are used.
- player_finish  in  PLAYERS  bit i high = player i crossed the finish line.
- current_screen  out  2  00 MENU, 11 COUNTDOWN, 01 GAME, 10 END.
- countdown_value  out  2  remaining countdown step; 0 outside COUNTDOWN.
- game_enable  out  1  high iff current_screen==GAME.
- winner  out  2  index of the winning player.
- winner_valid  out  1  winner holds a result.
- trigger_reset_all  out  1  one-cycle reset pulse for the race datapath.

Behaviour:
- Reset values (while reset high):
  - current_screen=00, countdown_value=0, game_enable=0.
  - winner=0, winner_valid=0, trigger_reset_all=0.
  - All counters 0; start edge register = 1.
  - Reset takes effect immediately, without waiting for a clock edge, including mid-state.
  - Reset never produces a trigger_reset_all pulse.
- Start edge detect: start_rise = start_btn & ~start_q, with start_q registered every cycle. Because start_q resets to 1, a button held through reset release does not start a race.
- All outputs are registered or a pure decode of registered state. No combinational path from inputs to outputs.
- MENU:
  - On start_rise: go to COUNTDOWN, countdown_value=COUNTDOWN_STEPS, step counter=0.
  - player_finish is ignored.
- COUNTDOWN:
  - Step counter increments every clock.
  - When counter==COUNTDOWN_CLK_COUNT-1: counter wraps to 0 and countdown_value decrements.
  - When this wrap occurs with countdown_value==1: go to GAME and set countdown_value=0.
  - Total duration is exactly COUNTDOWN_STEPS*COUNTDOWN_CLK_COUNT cycles. Each value N..1 is shown for COUNTDOWN_CLK_COUNT cycles.
  - start_rise and player_finish are ignored.
- GAME:
  - game_enable=1.
  - On the first cycle with any player_finish bit set: winner=lowest set index (simultaneous finishes resolve to the lowest index), winner_valid=1, go to END, end counter=0.
  - start_rise is ignored.
- END:
  - End counter increments every clock.
  - When counter==END_TIMER_CLK_COUNT-1, or on start_rise (early exit), whichever comes first: go to MENU, set trigger_reset_all=1 for the next cycle only, clear winner_valid.
  - END therefore lasts exactly END_TIMER_CLK_COUNT cycles unless exited early.
  - player_finish is ignored.
  - winner keeps its value until the next GAME result.
- MENU entry after END: trigger_reset_all is high during the first MENU cycle only. A start_rise in that cycle is accepted normally.
- Counter widths: $clog2 of the terminal count, minimum 1 bit. No overflow is possible, because counters wrap at terminal count.
- Unused encoding: none. All four screen codes are legal.

Test Plan:
Bench parameters: COUNTDOWN_CLK_COUNT=4, COUNTDOWN_STEPS=3, END_TIMER_CLK_COUNT=5, PLAYERS=4.

1. Hold start_btn=1 through reset release for 10 cycles -> current_screen stays 00. Then drop start_btn to 0 and raise it to 1 -> 11 on the next edge.
2. Start rise in MENU -> screen 11 for exactly 12 cycles with countdown_value 3,3,3,3,2,2,2,2,1,1,1,1; then 01, game_enable=1, countdown_value=0.
3. In GAME, player_finish=4'b0110 for one cycle -> next edge: screen 10, winner=1, winner_valid=1. Exactly 5 END cycles follow, then screen 00 with trigger_reset_all=1 for exactly 1 cycle and winner_valid=0.
4. Start rise on the 2nd END cycle -> MENU on the next edge, single trigger_reset_all pulse, no second pulse afterwards.
5. Assert reset mid-COUNTDOWN, asynchronously between edges -> outputs return to reset values immediately and trigger_reset_all stays 0.
6. player_finish=4'b1000 held during MENU and COUNTDOWN, and start rises during GAME -> no state change. Upon entering GAME with player_finish still 4'b1000 -> END next edge with winner=3.
